// File: rtl/prog_loader.sv
//------------------------------------------------------------------------------
// Module      : prog_loader
// Description : Receives a program as a valid/ready byte stream, packs three
//               bytes per 20-bit instruction into a local buffer, pads unused
//               slots with halt words, pulses the CPU reset, burst-writes the
//               buffer into CPU instruction memory, then runs the CPU until it
//               halts or a cycle budget expires.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module prog_loader #(
  parameter int          DEPTH     = 32,
  parameter logic [19:0] HALT_INST = 20'hC0000,
  parameter int          MAX_RUN   = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        byte_last,
  output logic        byte_ready,
  output logic [19:0] input_inst,
  output logic        inst_mem_read_write,
  output logic        cpu_rst_n,
  input  logic        cpu_halted,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] run_cycles
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RECV   = 3'd1,
    S_PAD    = 3'd2,
    S_CPURST = 3'd3,
    S_BURST  = 3'd4,
    S_RUN    = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [SW-1:0] r_slot;        // word slot while loading, burst index while bursting
  logic [SW-1:0] w_slot_nxt;
  logic [1:0]    r_bcnt;        // byte position within the current word
  logic [1:0]    w_bcnt_nxt;
  logic [3:0]    r_hi;
  logic [3:0]    w_hi_nxt;
  logic [7:0]    r_mid;
  logic [7:0]    w_mid_nxt;
  logic [19:0]   r_buf [DEPTH];

  logic          w_accept;
  logic          w_buf_we;
  logic [19:0]   w_buf_wdata;
  logic          w_done_nxt;
  logic          w_error_nxt;
  logic [15:0]   w_rc_nxt;
  logic [16:0]   w_rc_inc;
  logic          w_cpu_rst_n_nxt;
  logic          w_byte_ready_nxt;
  logic          w_busy_nxt;
  logic          w_mode_nxt;
  logic [19:0]   w_inst_nxt;

  assign w_accept = byte_valid && byte_ready;
  assign w_rc_inc = {1'b0, run_cycles} + 17'd1;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state, counter and next-output computation
  always_comb begin
    w_state_nxt     = r_state;
    w_slot_nxt      = r_slot;
    w_bcnt_nxt      = r_bcnt;
    w_hi_nxt        = r_hi;
    w_mid_nxt       = r_mid;
    w_done_nxt      = done;
    w_error_nxt     = error;
    w_rc_nxt        = run_cycles;
    w_cpu_rst_n_nxt = cpu_rst_n;
    w_buf_we        = 1'b0;
    w_buf_wdata     = HALT_INST;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          // A new program starts: its first byte is already word 0, byte 0.
          w_done_nxt      = 1'b0;
          w_error_nxt     = 1'b0;
          w_rc_nxt        = 16'd0;
          w_cpu_rst_n_nxt = 1'b0;
          w_slot_nxt      = '0;
          w_hi_nxt        = byte_in[3:0];
          w_bcnt_nxt      = 2'd1;
          if (byte_last) begin
            w_error_nxt = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (w_accept) begin
          if (r_bcnt == 2'd0) begin
            if (r_slot == SW'(DEPTH)) begin
              // Program longer than the buffer: abort without writing.
              w_error_nxt = 1'b1;
              w_state_nxt = S_DONE;
            end else begin
              w_hi_nxt   = byte_in[3:0];
              w_bcnt_nxt = 2'd1;
              if (byte_last) begin
                w_error_nxt = 1'b1;
                w_state_nxt = S_DONE;
              end
            end
          end else if (r_bcnt == 2'd1) begin
            w_mid_nxt  = byte_in;
            w_bcnt_nxt = 2'd2;
            if (byte_last) begin
              w_error_nxt = 1'b1;
              w_state_nxt = S_DONE;
            end
          end else begin
            w_buf_we    = 1'b1;
            w_buf_wdata = {r_hi, r_mid, byte_in};
            w_slot_nxt  = r_slot + SW'(1);
            w_bcnt_nxt  = 2'd0;
            if (byte_last) begin
              // A full buffer needs no padding.
              w_state_nxt = (r_slot == SW'(DEPTH - 1)) ? S_CPURST : S_PAD;
            end
          end
        end
      end
      S_PAD: begin
        w_buf_we    = 1'b1;
        w_buf_wdata = HALT_INST;
        w_slot_nxt  = r_slot + SW'(1);
        if (r_slot == SW'(DEPTH - 1)) w_state_nxt = S_CPURST;
      end
      S_CPURST: begin
        w_slot_nxt      = '0;
        w_cpu_rst_n_nxt = 1'b1;
        w_state_nxt     = S_BURST;
      end
      S_BURST: begin
        w_slot_nxt = r_slot + SW'(1);
        if (r_slot == SW'(DEPTH - 1)) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (cpu_halted) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          if (run_cycles != 16'hFFFF) w_rc_nxt = w_rc_inc[15:0];
          if (w_rc_inc >= 17'(MAX_RUN)) begin
            w_error_nxt = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Outputs follow the state being entered so they are registered yet aligned.
    w_byte_ready_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_RECV) ||
                       (w_state_nxt == S_DONE);
    w_busy_nxt       = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
    w_mode_nxt       = (w_state_nxt != S_BURST);
    w_inst_nxt       = (w_state_nxt == S_BURST) ? r_buf[w_slot_nxt[AW-1:0]] : 20'd0;
  end

  // Registered control, counters and outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot              <= '0;
      r_bcnt              <= 2'd0;
      r_hi                <= 4'd0;
      r_mid               <= 8'd0;
      byte_ready          <= 1'b0;
      input_inst          <= 20'd0;
      inst_mem_read_write <= 1'b1;
      cpu_rst_n           <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
      error               <= 1'b0;
      run_cycles          <= 16'd0;
    end else begin
      r_slot              <= w_slot_nxt;
      r_bcnt              <= w_bcnt_nxt;
      r_hi                <= w_hi_nxt;
      r_mid               <= w_mid_nxt;
      byte_ready          <= w_byte_ready_nxt;
      input_inst          <= w_inst_nxt;
      inst_mem_read_write <= w_mode_nxt;
      cpu_rst_n           <= w_cpu_rst_n_nxt;
      busy                <= w_busy_nxt;
      done                <= w_done_nxt;
      error               <= w_error_nxt;
      run_cycles          <= w_rc_nxt;
    end
  end

  // Program buffer; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (w_buf_we) r_buf[r_slot[AW-1:0]] <= w_buf_wdata;
  end

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
//------------------------------------------------------------------------------
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader. Expected burst words are
//               queued as each program is sent and popped during the burst.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_prog_loader;

  localparam int          DEPTH   = 32;
  localparam logic [19:0] HALT    = 20'hC0000;
  localparam int          MAX_RUN = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_last = 1'b0;
  logic        byte_ready;
  logic [19:0] input_inst;
  logic        inst_mem_read_write;
  logic        cpu_rst_n;
  logic        cpu_halted = 1'b0;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] run_cycles;

  int          total = 0;
  int          bad   = 0;
  logic [19:0] sb_q [$];

  prog_loader #(.DEPTH(DEPTH), .HALT_INST(HALT), .MAX_RUN(MAX_RUN)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .byte_in             (byte_in),
    .byte_valid          (byte_valid),
    .byte_last           (byte_last),
    .byte_ready          (byte_ready),
    .input_inst          (input_inst),
    .inst_mem_read_write (inst_mem_read_write),
    .cpu_rst_n           (cpu_rst_n),
    .cpu_halted          (cpu_halted),
    .busy                (busy),
    .done                (done),
    .error               (error),
    .run_cycles          (run_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_input_inst"}, 32'(input_inst), 32'd0);
    check({tag, "_mode"},       32'(inst_mem_read_write), 32'd1);
    check({tag, "_cpu_rst_n"},  32'(cpu_rst_n), 32'd0);
    check({tag, "_busy"},       32'(busy), 32'd0);
    check({tag, "_done"},       32'(done), 32'd0);
    check({tag, "_error"},      32'(error), 32'd0);
    check({tag, "_run_cycles"}, 32'(run_cycles), 32'd0);
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input logic last);
    int guard = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    byte_last  = last;
    while (!byte_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) check("byte_ready_wait", 32'(guard), 32'd0);
    @(negedge clk);
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  // The upper nibble of the first byte must be ignored, so fill it randomly.
  task automatic send_word(input logic [19:0] w, input logic last);
    logic [3:0] junk;
    junk = 4'($urandom_range(0, 15));
    send_byte({junk, w[19:16]}, 1'b0);
    send_byte(w[15:8], 1'b0);
    send_byte(w[7:0], last);
    sb_q.push_back(w);
  endtask

  task automatic pad_queue();
    while (sb_q.size() < DEPTH) sb_q.push_back(HALT);
  endtask

  // Checks the whole burst against the queue; returns at the first RUN negedge.
  task automatic run_burst(input string tag);
    int   guard = 0;
    logic prev_rst_n = 1'b1;
    logic [19:0] exp_w;
    while (inst_mem_read_write !== 1'b0 && guard < 300) begin
      prev_rst_n = cpu_rst_n;
      @(negedge clk);
      guard++;
    end
    check({tag, "_burst_start"}, 32'(guard < 300), 32'd1);
    check({tag, "_cpu_rst_before_burst"}, 32'(prev_rst_n), 32'd0);
    for (int k = 0; k < DEPTH; k++) begin
      exp_w = (sb_q.size() > 0) ? sb_q.pop_front() : 20'hFFFFF;
      check($sformatf("%s_inst_%0d", tag, k), 32'(input_inst), 32'(exp_w));
      check($sformatf("%s_ctl_%0d", tag, k), {30'd0, inst_mem_read_write, cpu_rst_n}, 32'd1);
      @(negedge clk);
    end
    check({tag, "_run_mode"}, 32'(inst_mem_read_write), 32'd1);
    check({tag, "_run_inst"}, 32'(input_inst), 32'd0);
    check({tag, "_run_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic halt_after(input int n);
    repeat (n) @(negedge clk);
    cpu_halted = 1'b1;
    @(negedge clk);
    cpu_halted = 1'b0;
  endtask

  task automatic check_done(input string tag, input int rc);
    check({tag, "_done"},       32'(done), 32'd1);
    check({tag, "_error"},      32'(error), 32'd0);
    check({tag, "_run_cycles"}, 32'(run_cycles), 32'(rc));
    check({tag, "_busy"},       32'(busy), 32'd0);
    check({tag, "_cpu_rst_n"},  32'(cpu_rst_n), 32'd1);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd1);
  endtask

  initial begin
    logic [19:0] w;
    logic [7:0]  iv;
    int          guard;
    logic        saw_burst;

    // Reset values
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;

    // Single-word program padded with halts
    sb_q.delete();
    send_byte(8'h0A, 1'b0);
    send_byte(8'hBC, 1'b0);
    send_byte(8'hDE, 1'b1);
    sb_q.push_back(20'hABCDE);
    pad_queue();
    run_burst("one_word");
    halt_after(0);
    check_done("one_word", 0);

    // Two words plus a halt word; halted seven cycles into RUN
    sb_q.delete();
    send_word(20'h12345, 1'b0);
    check("restart_done_cleared", 32'(done), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    send_word(20'hF6789, 1'b0);
    send_word(20'hC0000, 1'b1);
    pad_queue();
    run_burst("three_word");
    halt_after(7);
    check_done("three_word", 7);

    // Exactly DEPTH words, last on the final byte: no padding
    sb_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      iv = 8'(i);
      w  = {iv[3:0] ^ 4'h9, iv * 8'd7, 8'hFF - iv};
      send_word(w, i == DEPTH - 1);
    end
    run_burst("full");
    halt_after(2);
    check_done("full", 2);

    // Overflow: 96 bytes without last, then three more
    sb_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      iv = 8'(i);
      send_word({4'h3, iv, ~iv}, 1'b0);
    end
    sb_q.delete();
    send_byte(8'h11, 1'b0);
    check("overflow_error", 32'(error), 32'd1);
    check("overflow_busy", 32'(busy), 32'd0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    check("overflow99_error", 32'(error), 32'd1);
    check("overflow99_done", 32'(done), 32'd0);
    check("overflow99_mode", 32'(inst_mem_read_write), 32'd1);

    // byte_last on the second byte of a word
    send_word(20'h11111, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h06, 1'b1);
    sb_q.delete();
    check("partial_error", 32'(error), 32'd1);
    check("partial_done", 32'(done), 32'd0);
    check("partial_busy", 32'(busy), 32'd0);
    saw_burst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (inst_mem_read_write !== 1'b1) saw_burst = 1'b1;
      @(negedge clk);
    end
    check("partial_no_burst", 32'(saw_burst), 32'd0);

    // Run timeout: halted never rises
    sb_q.delete();
    send_word(20'h00001, 1'b1);
    pad_queue();
    run_burst("timeout");
    guard = 0;
    while (!(error || done) && guard < MAX_RUN + 100) begin
      @(negedge clk);
      guard++;
    end
    check("timeout_cycles_to_error", 32'(guard), 32'(MAX_RUN));
    check("timeout_error", 32'(error), 32'd1);
    check("timeout_done", 32'(done), 32'd0);
    check("timeout_run_cycles", 32'(run_cycles), 32'(MAX_RUN));
    check("timeout_busy", 32'(busy), 32'd0);

    // Asynchronous reset during burst cycle 10, then a fresh load
    sb_q.delete();
    send_word(20'h2468A, 1'b1);
    guard = 0;
    while (inst_mem_read_write !== 1'b0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("midreset_burst_start", 32'(guard < 300), 32'd1);
    repeat (10) @(negedge clk);
    check("midreset_in_burst", 32'(inst_mem_read_write), 32'd0);
    rst = 1'b0;
    #1;
    check_reset_vals("midreset");
    @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    send_word(20'h35A5A, 1'b0);
    send_word(20'h0BEEF, 1'b1);
    pad_queue();
    run_burst("after_reset");
    halt_after(3);
    check_done("after_reset", 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
